// File: rtl/gamma_inverse_lut.sv
// Inverse-gamma lookup: builds inv[] from a host-loaded forward curve with a
// two-pointer sweep, then linearises pixels through a 1-cycle registered lookup.
module gamma_inverse_lut #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fwd_we,
  input  logic [DATA_W-1:0] i_fwd_addr,
  input  logic [DATA_W-1:0] i_fwd_data,
  input  logic              i_build,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_table_ok,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  localparam int                DEPTH = 1 << DATA_W;
  localparam logic [DATA_W-1:0] MAXV  = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] fwd_mem [DEPTH];
  logic [DATA_W-1:0] inv_mem [DEPTH];

  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] fwd_rd_p1;

  logic              hit;
  logic              exhausted;
  logic              inv_we;
  logic [DATA_W-1:0] inv_wdata;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // When the forward curve never reaches y, the inverse clamps to full scale.
  function automatic logic [DATA_W-1:0] sat_index(input logic [DATA_W-1:0] x,
                                                  input logic              found);
    return found ? x : MAXV;
  endfunction

  always_comb begin
    hit       = (fwd_rd_p1 >= y_q);
    exhausted = (x_q == MAXV);
    inv_we    = (state == S_CMP) && (hit || exhausted);
    inv_wdata = sat_index(x_q, hit);
  end

  // Host write port; locked out while the sweep is reading the curve.
  always_ff @(posedge clk) begin
    if (i_fwd_we && !o_busy)
      fwd_mem[i_fwd_addr] <= i_fwd_data;
  end

  // RD -> CMP boundary: synchronous forward-table read.
  always_ff @(posedge clk) begin
    if (state == S_RD)
      fwd_rd_p1 <= fwd_mem[x_q];
  end

  always_ff @(posedge clk) begin
    if (inv_we)
      inv_mem[y_q] <= inv_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_table_ok <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_build) begin
            state      <= S_RD;
            o_busy     <= 1'b1;
            o_table_ok <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
          end
        end
        S_RD: begin
          state <= S_CMP;
        end
        S_CMP: begin
          if (hit || exhausted) begin
            if (y_q == MAXV) begin
              state      <= S_DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_table_ok <= 1'b1;
            end else begin
              y_q   <= y_q + 1'b1;
              state <= S_RD;
            end
          end else begin
            x_q   <= x_q + 1'b1;
            state <= S_RD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Input -> p1 boundary: lookup (or bypass until a table has been built).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= i_valid;
      if (i_valid)
        data_p1 <= o_table_ok ? inv_mem[i_data] : i_data;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;

endmodule
